// File: rtl/scd_shift_count.sv
// Shift-count / exponent datapath (SC, FE, SCAD) with the multiply/divide/shift loop sequencer.
// Optional EBUS diagnostic mux enabled by defining SCD_DIAG_EN.
module scd_shift_count #(
    parameter int unsigned SCW     = 10,
    parameter int unsigned MAXITER = 37
) (
    input  logic           clk,
    input  logic           reset,
`ifdef SCD_DIAG_EN
    input  logic [2:0]     diagSel,
    output logic [35:0]    diagOut,
`endif
    input  logic [8:0]     ARexp,
    input  logic [9:0]     ARshift,
    input  logic [8:0]     magic,
    input  logic [1:0]     scadAsel,
    input  logic [1:0]     scadBsel,
    input  logic [2:0]     scadOp,
    input  logic           scLoad,
    input  logic           feLoad,
    input  logic           loopStart,
    input  logic [1:0]     loopKind,
    input  logic           adCarry0,
    output logic [SCW-1:0] SC,
    output logic [SCW-1:0] FE,
    output logic [SCW-1:0] SCAD,
    output logic           scSign,
    output logic           feSign,
    output logic [1:0]     MQselOut,
    output logic [3:0]     ADselOvr,
    output logic           ADovrEn,
    output logic           loopBusy,
    output logic           loopDone,
    output logic           divOverflow
);

    localparam int unsigned ITW = ($clog2(MAXITER) > 0) ? $clog2(MAXITER) : 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t           r_state, w_state_next;
    logic [SCW-1:0]   r_sc, w_sc_next;
    logic [SCW-1:0]   r_fe, w_fe_next;
    logic [1:0]       r_kind, w_kind_next;
    logic [ITW-1:0]   r_iter, w_iter_next;
    logic             r_ovf, w_ovf_next;
    logic [1:0]       r_mq, w_mq_next;
    logic [3:0]       r_adsel, w_adsel_next;
    logic             r_ovr_en, w_ovr_en_next;
    logic             r_busy, w_busy_next;
    logic             r_done, w_done_next;

    logic [SCW-1:0]   w_scad, w_a, w_b, w_magic_sx, w_arexp_sx;
    logic             w_start_le0;

    // 9-bit fields carry the DEC sign (bit 0) in vector bit 8
    assign w_magic_sx = {{(SCW-9){magic[8]}}, magic};
    assign w_arexp_sx = {{(SCW-9){ARexp[8]}}, ARexp};

    always_comb begin
        w_a = r_fe;
        case (scadAsel)
            2'b00: w_a = r_fe;
            2'b01: w_a = w_arexp_sx;
            2'b10: w_a = SCW'(ARshift);
            2'b11: w_a = w_magic_sx;
            default: w_a = r_fe;
        endcase
    end

    always_comb begin
        w_b = r_sc;
        case (scadBsel)
            2'b00: w_b = r_sc;
            2'b01: w_b = w_magic_sx;
            2'b10: w_b = SCW'(ARexp);
            2'b11: w_b = '0;
            default: w_b = r_sc;
        endcase
    end

    always_comb begin
        w_scad = w_a;
        case (scadOp)
            3'b000: w_scad = w_a;
            3'b001: w_scad = w_a + w_b;
            3'b010: w_scad = w_a - w_b;
            3'b011: w_scad = w_a + SCW'(1);
            3'b100: w_scad = w_a - SCW'(1);
            3'b101: w_scad = w_a | w_b;
            3'b110: w_scad = w_a & w_b;
            3'b111: w_scad = w_b;
            default: w_scad = w_a;
        endcase
    end

    assign w_start_le0 = w_scad[SCW-1] | (w_scad == '0);
    assign w_fe_next   = feLoad ? w_scad : r_fe;

    // Next-state logic; outputs are precomputed from the next state so they leave registers
    always_comb begin
        w_state_next  = r_state;
        w_sc_next     = r_sc;
        w_kind_next   = r_kind;
        w_iter_next   = r_iter;
        w_ovf_next    = r_ovf;
        w_mq_next     = 2'b11;
        w_adsel_next  = 4'b0000;
        w_ovr_en_next = 1'b0;
        w_busy_next   = 1'b0;
        w_done_next   = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (loopStart) begin
                    w_sc_next    = w_scad - SCW'(1);
                    w_iter_next  = '0;
                    w_kind_next  = loopKind;
                    w_ovf_next   = 1'b0;
                    w_state_next = w_start_le0 ? ST_DONE : ST_RUN;
                end else if (scLoad) begin
                    w_sc_next = w_scad;
                end
            end
            ST_RUN: begin
                w_sc_next   = r_sc - SCW'(1);
                w_iter_next = r_iter + ITW'(1);
                if (r_kind == 2'b11 && r_iter == '0 && !adCarry0) begin
                    w_state_next = ST_DONE;
                    w_ovf_next   = 1'b1;
                end else if (r_sc == '0 || r_iter == ITW'(MAXITER - 1)) begin
                    w_state_next = ST_DONE;
                end
            end
            ST_DONE: w_state_next = ST_IDLE;
            default: w_state_next = ST_IDLE;
        endcase

        w_busy_next = (w_state_next != ST_IDLE);
        w_done_next = (w_state_next == ST_DONE);
        if (w_state_next == ST_RUN) begin
            case (w_kind_next)
                2'b00: w_mq_next = 2'b10;
                2'b01: w_mq_next = 2'b01;
                2'b10: begin
                    w_mq_next     = 2'b10;
                    w_ovr_en_next = 1'b1;
                    w_adsel_next  = 4'b0110;
                end
                2'b11: begin
                    w_mq_next     = 2'b01;
                    w_ovr_en_next = 1'b1;
                    // adCarry0 seen now becomes "previous" carry in the next RUN cycle
                    w_adsel_next  = adCarry0 ? 4'b0110 : 4'b1001;
                end
                default: w_mq_next = 2'b11;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= ST_IDLE;
            r_sc     <= '0;
            r_fe     <= '0;
            r_kind   <= '0;
            r_iter   <= '0;
            r_ovf    <= 1'b0;
            r_mq     <= 2'b11;
            r_adsel  <= 4'b0000;
            r_ovr_en <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_state  <= w_state_next;
            r_sc     <= w_sc_next;
            r_fe     <= w_fe_next;
            r_kind   <= w_kind_next;
            r_iter   <= w_iter_next;
            r_ovf    <= w_ovf_next;
            r_mq     <= w_mq_next;
            r_adsel  <= w_adsel_next;
            r_ovr_en <= w_ovr_en_next;
            r_busy   <= w_busy_next;
            r_done   <= w_done_next;
        end
    end

    assign SC          = r_sc;
    assign FE          = r_fe;
    assign SCAD        = w_scad;
    assign scSign      = r_sc[SCW-1];
    assign feSign      = r_fe[SCW-1];
    assign MQselOut    = r_mq;
    assign ADselOvr    = r_adsel;
    assign ADovrEn     = r_ovr_en;
    assign loopBusy    = r_busy;
    assign loopDone    = r_done;
    assign divOverflow = r_ovf;

`ifdef SCD_DIAG_EN
    always_comb begin
        diagOut = '0;
        case (diagSel)
            3'b000:  diagOut = 36'(r_sc);
            3'b001:  diagOut = 36'(r_fe);
            3'b010:  diagOut = 36'(w_scad);
            3'b011:  diagOut = 36'({r_state, r_kind, r_ovf, r_busy});
            default: diagOut = '0;
        endcase
    end
`endif

endmodule

// File: tb/tb_scd_shift_count.sv
// Scoreboard bench for scd_shift_count: loop transactions are queued at start and
// checked by a monitor on every MQ-active cycle and on loopDone.
module tb_scd_shift_count;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [8:0] ARexp = '0;
    logic [9:0] ARshift = '0;
    logic [8:0] magic = '0;
    logic [1:0] scadAsel = '0;
    logic [1:0] scadBsel = 2'b11;
    logic [2:0] scadOp = '0;
    logic       scLoad = 1'b0;
    logic       feLoad = 1'b0;
    logic       loopStart = 1'b0;
    logic [1:0] loopKind = '0;
    logic       adCarry0 = 1'b1;
    logic [9:0] SC, FE, SCAD;
    logic       scSign, feSign;
    logic [1:0] MQselOut;
    logic [3:0] ADselOvr;
    logic       ADovrEn, loopBusy, loopDone, divOverflow;

    scd_shift_count dut (
        .clk(clk), .reset(reset), .ARexp(ARexp), .ARshift(ARshift), .magic(magic),
        .scadAsel(scadAsel), .scadBsel(scadBsel), .scadOp(scadOp), .scLoad(scLoad),
        .feLoad(feLoad), .loopStart(loopStart), .loopKind(loopKind), .adCarry0(adCarry0),
        .SC(SC), .FE(FE), .SCAD(SCAD), .scSign(scSign), .feSign(feSign),
        .MQselOut(MQselOut), .ADselOvr(ADselOvr), .ADovrEn(ADovrEn),
        .loopBusy(loopBusy), .loopDone(loopDone), .divOverflow(divOverflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] mq;
        logic [3:0] adsel;
        logic       ovr_en;
        int         run;
        logic [9:0] sc;
        logic       ovf;
        logic       aborted;
    } exp_t;

    exp_t q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   run_cnt = 0;
    exp_t m_e;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: compare each MQ-active cycle and each loopDone against the queue head
    always @(negedge clk) begin
        if (reset) begin
            if (q.size() > 0 && q[0].aborted) void'(q.pop_front());
            run_cnt = 0;
        end else begin
            if (MQselOut != 2'b11) begin
                if (q.size() == 0) begin
                    chk("mq_unexpected", 32'(MQselOut), 32'h3);
                end else begin
                    run_cnt++;
                    chk("mq_code", 32'(MQselOut), 32'(q[0].mq));
                    chk("ad_en", 32'(ADovrEn), 32'(q[0].ovr_en));
                    chk("ad_sel", 32'(ADselOvr), 32'(q[0].adsel));
                end
            end
            if (loopDone) begin
                if (q.size() == 0) begin
                    chk("done_unexpected", 32'(loopDone), 32'h0);
                end else begin
                    m_e = q.pop_front();
                    chk("run_cycles", 32'(run_cnt), 32'(m_e.run));
                    chk("sc_at_done", 32'(SC), 32'(m_e.sc));
                    chk("ovf_at_done", 32'(divOverflow), 32'(m_e.ovf));
                    chk("busy_at_done", 32'(loopBusy), 32'h1);
                    chk("aden_at_done", 32'(ADovrEn), 32'h0);
                    run_cnt = 0;
                end
            end
        end
    end

    task automatic start_loop(input logic [8:0] cnt, input logic [1:0] kind, input exp_t e);
        q.push_back(e);
        magic     = cnt;
        scadAsel  = 2'b11;
        scadOp    = 3'b000;
        loopKind  = kind;
        loopStart = 1'b1;
        @(posedge clk); #1;
        loopStart = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int i = 0;
        while (q.size() != 0 && i < budget) begin
            @(posedge clk); #1;
            i++;
        end
        scLoad = 1'b0;
        chk("loop_timeout", 32'(q.size()), 32'h0);
        q.delete();
        @(posedge clk); #1;
    endtask

    task automatic load_reg(input logic fe, input logic [1:0] a, input logic [1:0] b,
                            input logic [2:0] op);
        scadAsel = a; scadBsel = b; scadOp = op;
        if (fe) feLoad = 1'b1; else scLoad = 1'b1;
        @(posedge clk); #1;
        feLoad = 1'b0; scLoad = 1'b0;
    endtask

    // SCAD vectors: asel, bsel, op, magic, ARexp, ARshift, expected (FE = 10'h07F)
    typedef struct {
        logic [1:0] a; logic [1:0] b; logic [2:0] op;
        logic [8:0] mg; logic [8:0] ax; logic [9:0] ash; logic [9:0] exp;
    } svec_t;
    svec_t sv[8];

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t e;
        sv[0] = '{2'b10, 2'b11, 3'b000, 9'h000, 9'h000, 10'h2A5, 10'h2A5};
        sv[1] = '{2'b10, 2'b01, 3'b101, 9'h0F0, 9'h000, 10'h2A5, 10'h2F5};
        sv[2] = '{2'b10, 2'b01, 3'b110, 9'h0F0, 9'h000, 10'h2A5, 10'h0A0};
        sv[3] = '{2'b11, 2'b11, 3'b011, 9'h100, 9'h000, 10'h000, 10'h301};
        sv[4] = '{2'b11, 2'b11, 3'b100, 9'h000, 9'h000, 10'h000, 10'h3FF};
        sv[5] = '{2'b11, 2'b10, 3'b111, 9'h000, 9'h1FF, 10'h000, 10'h1FF};
        sv[6] = '{2'b01, 2'b10, 3'b010, 9'h000, 9'h1FF, 10'h000, 10'h200};
        sv[7] = '{2'b00, 2'b11, 3'b001, 9'h000, 9'h000, 10'h000, 10'h07F};

        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(posedge clk); #1;
        chk("rst_sc", 32'(SC), 32'h0);
        chk("rst_fe", 32'(FE), 32'h0);
        chk("rst_mq", 32'(MQselOut), 32'h3);
        chk("rst_busy", 32'(loopBusy), 32'h0);
        chk("rst_done", 32'(loopDone), 32'h0);
        chk("rst_ovf", 32'(divOverflow), 32'h0);
        chk("rst_aden", 32'(ADovrEn), 32'h0);

        // FE / SC loading through SCAD
        magic = 9'o150; load_reg(1'b1, 2'b11, 2'b11, 3'b000);
        chk("fe_magic", 32'(FE), 32'o150);
        ARexp = 9'o200; load_reg(1'b1, 2'b01, 2'b11, 3'b010);
        chk("fe_arexp", 32'(FE), 32'o200);
        magic = 9'o777; load_reg(1'b1, 2'b00, 2'b01, 3'b001);
        chk("fe_dec", 32'(FE), 32'o177);
        magic = 9'o012; load_reg(1'b0, 2'b11, 2'b11, 3'b000);
        chk("sc_load", 32'(SC), 32'h00A);

        for (int i = 0; i < 8; i++) begin
            scadAsel = sv[i].a; scadBsel = sv[i].b; scadOp = sv[i].op;
            magic = sv[i].mg; ARexp = sv[i].ax; ARshift = sv[i].ash;
            @(negedge clk);
            chk($sformatf("scad_vec%0d", i), 32'(SCAD), 32'(sv[i].exp));
        end
        @(posedge clk); #1;
        scadBsel = 2'b11;

        // Shift right, count 5
        e = '{2'b10, 4'h0, 1'b0, 5, 10'h3FF, 1'b0, 1'b0};
        start_loop(9'o005, 2'b00, e);
        chk("busy_run", 32'(loopBusy), 32'h1);
        wait_done(20);
        chk("mq_idle_after", 32'(MQselOut), 32'h3);

        // Degenerate counts go straight to DONE
        e = '{2'b10, 4'h0, 1'b0, 0, 10'h3FF, 1'b0, 1'b0};
        start_loop(9'h000, 2'b00, e);
        wait_done(5);
        e = '{2'b10, 4'h0, 1'b0, 0, 10'h3EF, 1'b0, 1'b0};
        start_loop(9'h1F0, 2'b00, e);
        wait_done(5);

        // Shift left with scLoad held: loop owns SC
        scLoad = 1'b1;
        e = '{2'b01, 4'h0, 1'b0, 3, 10'h3FF, 1'b0, 1'b0};
        start_loop(9'o003, 2'b01, e);
        wait_done(60);

        // Divide overflow on first step
        adCarry0 = 1'b0;
        e = '{2'b01, 4'h9, 1'b1, 1, 10'h006, 1'b1, 1'b0};
        start_loop(9'o010, 2'b11, e);
        wait_done(20);
        repeat (3) @(posedge clk);
        #1 chk("ovf_sticky", 32'(divOverflow), 32'h1);

        // Divide without overflow
        adCarry0 = 1'b1;
        e = '{2'b01, 4'h6, 1'b1, 8, 10'h3FF, 1'b0, 1'b0};
        start_loop(9'o010, 2'b11, e);
        chk("ovf_cleared", 32'(divOverflow), 32'h0);
        wait_done(20);

        // Multiply capped at MAXITER
        e = '{2'b10, 4'h6, 1'b1, 37, 10'h016, 1'b0, 1'b0};
        start_loop(9'd60, 2'b10, e);
        wait_done(60);

        // Reset mid-loop aborts without loopDone
        e = '{2'b10, 4'h6, 1'b1, 10, 10'h000, 1'b0, 1'b1};
        start_loop(9'd10, 2'b10, e);
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        chk("abort_mq", 32'(MQselOut), 32'h3);
        chk("abort_busy", 32'(loopBusy), 32'h0);
        chk("abort_done", 32'(loopDone), 32'h0);
        chk("abort_aden", 32'(ADovrEn), 32'h0);
        repeat (12) @(posedge clk);
        #1 chk("queue_empty", 32'(q.size()), 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
